// File: rtl/rope_pkg.sv
// Shared definitions for the rope collision block: FSM state encoding,
// coordinate widths, the fixed-point scale used by the rope mover, and
// small arithmetic helpers shared by the top and its sub-module.
package rope_pkg;

    localparam int COORD_W                = 11;
    localparam int CALC_W                 = 12;
    localparam int FIXED_POINT_MULTIPLIER = 64;

    typedef enum logic [1:0] {
        ST_ARMED    = 2'd0,
        ST_FIRE     = 2'd1,
        ST_COOLDOWN = 2'd2
    } rope_state_t;

    // Sign-extend a signed screen coordinate into the working width.
    function automatic logic [CALC_W-1:0] sext_coord(input logic [COORD_W-1:0] v);
        return {v[COORD_W-1], v};
    endfunction

    // Zero-extend an unsigned scan coordinate into the working width.
    function automatic logic [CALC_W-1:0] zext_coord(input logic [COORD_W-1:0] v);
        return {1'b0, v};
    endfunction

    // 8-bit increment that sticks at the top value.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'd255) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/rope_collision_ctrl_frame_event_latch.sv
// Sticky per-frame left/right hit flags. The sample outputs fold in a hit
// occurring in the current cycle, so a hit coinciding with startOfFrame is
// seen by the frame being closed and is also carried into the new frame.
module frame_event_latch (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic hit_left,
    input  logic hit_right,
    output logic sample_left,
    output logic sample_right
);

    logic hit_l_r;
    logic hit_r_r;

    // Frame summary as seen at the startOfFrame edge, including this cycle.
    always_comb begin
        sample_left  = hit_l_r | hit_left;
        sample_right = hit_r_r | hit_right;
    end

    // Accumulate hits during the frame; restart from the current hit at frame start.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit_l_r <= 1'b0;
            hit_r_r <= 1'b0;
        end else if (startOfFrame) begin
            hit_l_r <= hit_left;
            hit_r_r <= hit_right;
        end else begin
            hit_l_r <= hit_l_r | hit_left;
            hit_r_r <= hit_r_r | hit_right;
        end
    end

endmodule

// File: rtl/rope_collision_ctrl.sv
// Rope collision controller: classifies rope/boundary pixel overlaps as
// left or right hits, summarises them per frame and issues a single-cycle
// dirToggle to the rope mover when the rope is moving into the hit side,
// followed by a cooldown of COOLDOWN_FRAMES frames.
// Optional feature: ROPE_COLL_POSLIMIT_EN adds position-limit triggers
// (topLeftX below X_MIN or right edge beyond X_MAX while moving outward).
module rope_collision_ctrl
    import rope_pkg::*;
#(
    parameter int X_MIN           = 16,
    parameter int X_MAX           = 560,
    parameter int ROPE_WIDTH      = 32,
    parameter int COOLDOWN_FRAMES = 4
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                startOfFrame,
    input  logic                ropeDrawReq,
    input  logic                boundaryDrawReq,
    input  logic [COORD_W-1:0]  pixelX,
    input  logic [COORD_W-1:0]  topLeftX,
    input  logic [31:0]         SPEED,
    output logic                dirToggle,
    output logic                collision,
    output logic [7:0]          hitCount
);

`ifdef ROPE_COLL_POSLIMIT_EN
    localparam logic POSLIMIT_EN = 1'b1;
`else
    localparam logic POSLIMIT_EN = 1'b0;
`endif

    localparam logic [CALC_W-1:0] HALF_W_C  = CALC_W'(ROPE_WIDTH / 2);
    localparam logic [CALC_W-1:0] ROPE_W_C  = CALC_W'(ROPE_WIDTH);
    localparam logic [CALC_W-1:0] X_MIN_C   = CALC_W'(X_MIN);
    localparam logic [CALC_W-1:0] X_MAX_C   = CALC_W'(X_MAX);
    localparam logic [3:0]        COOL_N_C  = 4'(COOLDOWN_FRAMES);
    localparam logic              NO_COOL_C = (COOLDOWN_FRAMES == 0);

    logic              hit_s;
    logic              hit_left_s;
    logic              hit_right_s;
    logic              sample_left_s;
    logic              sample_right_s;
    logic              speed_neg_s;
    logic              speed_pos_s;
    logic              pixel_qual_s;
    logic              limit_qual_s;
    logic              qual_s;
    logic [CALC_W-1:0] tlx_s;
    logic [CALC_W-1:0] px_s;

    rope_state_t       state_r;
    logic [3:0]        cool_cnt_r;
    logic              dir_toggle_r;
    logic              collision_r;
    logic [7:0]        hit_count_r;

    // Classify the current overlap pixel against the rope centre line in signed 12-bit.
    always_comb begin
        tlx_s       = sext_coord(topLeftX);
        px_s        = zext_coord(pixelX);
        hit_s       = ropeDrawReq & boundaryDrawReq;
        hit_left_s  = 1'b0;
        hit_right_s = 1'b0;
        if (hit_s) begin
            if ($signed(px_s) < $signed(tlx_s + HALF_W_C)) begin
                hit_left_s = 1'b1;
            end else begin
                hit_right_s = 1'b1;
            end
        end else begin
            hit_left_s  = 1'b0;
            hit_right_s = 1'b0;
        end
    end

    frame_event_latch u_latch (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .hit_left     (hit_left_s),
        .hit_right    (hit_right_s),
        .sample_left  (sample_left_s),
        .sample_right (sample_right_s)
    );

    // Decide whether the frame summary (and optional position limits) call for a toggle.
    always_comb begin
        speed_neg_s  = SPEED[31];
        speed_pos_s  = ~SPEED[31] & (|SPEED);
        pixel_qual_s = (sample_left_s & ~sample_right_s & speed_neg_s) |
                       (sample_right_s & ~sample_left_s & speed_pos_s);
        limit_qual_s = (($signed(tlx_s) < $signed(X_MIN_C)) & speed_neg_s) |
                       (($signed(tlx_s + ROPE_W_C) > $signed(X_MAX_C)) & speed_pos_s);
        qual_s       = pixel_qual_s | (POSLIMIT_EN & limit_qual_s);
    end

    // Toggle FSM with registered pulse output, cooldown frame counter and saturating hit count.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r      <= ST_ARMED;
            cool_cnt_r   <= 4'd0;
            dir_toggle_r <= 1'b0;
            hit_count_r  <= 8'd0;
        end else begin
            case (state_r)
                ST_ARMED: begin
                    cool_cnt_r <= 4'd0;
                    if (startOfFrame && qual_s) begin
                        state_r      <= ST_FIRE;
                        dir_toggle_r <= 1'b1;
                        hit_count_r  <= sat_inc8(hit_count_r);
                    end else begin
                        dir_toggle_r <= 1'b0;
                    end
                end
                ST_FIRE: begin
                    dir_toggle_r <= 1'b0;
                    cool_cnt_r   <= 4'd0;
                    state_r      <= NO_COOL_C ? ST_ARMED : ST_COOLDOWN;
                end
                ST_COOLDOWN: begin
                    dir_toggle_r <= 1'b0;
                    if (startOfFrame) begin
                        if ((cool_cnt_r + 4'd1) >= COOL_N_C) begin
                            state_r    <= ST_ARMED;
                            cool_cnt_r <= 4'd0;
                        end else begin
                            cool_cnt_r <= cool_cnt_r + 4'd1;
                        end
                    end
                end
                default: begin
                    state_r      <= ST_ARMED;
                    cool_cnt_r   <= 4'd0;
                    dir_toggle_r <= 1'b0;
                end
            endcase
        end
    end

    // Collision level reflects whether the frame just closed had any hit.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            collision_r <= 1'b0;
        end else if (startOfFrame) begin
            collision_r <= sample_left_s | sample_right_s;
        end
    end

    assign dirToggle = dir_toggle_r;
    assign collision = collision_r;
    assign hitCount  = hit_count_r;

endmodule

// File: tb/tb_rope_collision_ctrl.sv
// Scoreboard bench for rope_collision_ctrl: each issued frame pushes its
// expected (pulse, collision, hitCount) result; a monitor pops and compares
// on the cycle after every startOfFrame.
module tb_rope_collision_ctrl;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        ropeDrawReq = 1'b0;
    logic        boundaryDrawReq = 1'b0;
    logic [10:0] pixelX = 11'd0;
    logic [10:0] topLeftX = 11'd100;
    logic [31:0] SPEED = 32'd0;
    logic        dirToggle;
    logic        collision;
    logic [7:0]  hitCount;

    typedef struct {
        logic       fire;
        logic       coll;
        logic [7:0] hc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          pulse_seen = 0;
    int          exp_pulses = 0;
    logic [7:0]  exp_hc = 8'd0;

    rope_collision_ctrl dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .ropeDrawReq     (ropeDrawReq),
        .boundaryDrawReq (boundaryDrawReq),
        .pixelX          (pixelX),
        .topLeftX        (topLeftX),
        .SPEED           (SPEED),
        .dirToggle       (dirToggle),
        .collision       (collision),
        .hitCount        (hitCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of rope/boundary overlap at the given scan X.
    task automatic hit(input logic [10:0] px);
        @(negedge clk);
        ropeDrawReq     = 1'b1;
        boundaryDrawReq = 1'b1;
        pixelX          = px;
        @(negedge clk);
        ropeDrawReq     = 1'b0;
        boundaryDrawReq = 1'b0;
    endtask

    // Close a frame; optionally with a hit in the startOfFrame cycle itself.
    task automatic frame(input logic fire, input logic coll, input logic sof_hit, input logic [10:0] px);
        @(negedge clk);
        startOfFrame = 1'b1;
        if (sof_hit) begin
            ropeDrawReq     = 1'b1;
            boundaryDrawReq = 1'b1;
            pixelX          = px;
        end
        if (fire) begin
            exp_hc = (exp_hc == 8'd255) ? 8'd255 : exp_hc + 8'd1;
            exp_pulses++;
        end
        exp_q.push_back('{fire, coll, exp_hc});
        @(negedge clk);
        startOfFrame    = 1'b0;
        ropeDrawReq     = 1'b0;
        boundaryDrawReq = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic empty_frames(input int n);
        for (int i = 0; i < n; i++) frame(1'b0, 1'b0, 1'b0, 11'd0);
    endtask

    // Monitor: after each startOfFrame edge compare the DUT response with the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (startOfFrame === 1'b1 && resetN === 1'b1) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("dirToggle", int'(dirToggle), int'(e.fire));
                    chk("collision", int'(collision), int'(e.coll));
                    chk("hitCount", int'(hitCount), int'(e.hc));
                end
                @(negedge clk);
                chk("pulse_width", int'(dirToggle), 0);
            end
        end
    end

    // Count every cycle dirToggle is high to catch stray pulses.
    always @(negedge clk) begin
        if (dirToggle === 1'b1) pulse_seen <= pulse_seen + 1;
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dirToggle", int'(dirToggle), 0);
        chk("rst_collision", int'(collision), 0);
        chk("rst_hitCount", int'(hitCount), 0);
        resetN = 1'b1;
        repeat (2) @(negedge clk);

        // Idle frame.
        frame(1'b0, 1'b0, 1'b0, 11'd0);

        // Moving right, right-side hit at topLeftX+30 -> pulse next frame start.
        SPEED = 32'sd30;
        hit(11'd130);
        frame(1'b1, 1'b1, 1'b0, 11'd0);
        empty_frames(4);

        // Moving left, right-side hit -> collision only.
        SPEED = -32'sd30;
        hit(11'd130);
        frame(1'b0, 1'b1, 1'b0, 11'd0);

        // Both sides hit while moving right -> no pulse.
        SPEED = 32'sd30;
        hit(11'd105);
        hit(11'd130);
        frame(1'b0, 1'b1, 1'b0, 11'd0);

        // Stationary with left hit -> no pulse.
        SPEED = 32'sd0;
        hit(11'd105);
        frame(1'b0, 1'b1, 1'b0, 11'd0);

        // Moving left, left hit -> pulse.
        SPEED = -32'sd30;
        hit(11'd115);
        frame(1'b1, 1'b1, 1'b0, 11'd0);
        empty_frames(4);

        // Six consecutive qualifying frames -> pulses on the first and sixth.
        SPEED = 32'sd30;
        for (int f = 0; f < 6; f++) begin
            hit(11'd130);
            frame((f == 0) || (f == 5), 1'b1, 1'b0, 11'd0);
        end
        empty_frames(4);

        // Hit in the startOfFrame cycle: counted now and in the following frame.
        frame(1'b1, 1'b1, 1'b1, 11'd116);
        frame(1'b0, 1'b1, 1'b0, 11'd0);
        empty_frames(3);

        // Rope past the right limit with no pixel hit.
        topLeftX = 11'd540;
`ifdef ROPE_COLL_POSLIMIT_EN
        frame(1'b1, 1'b0, 1'b0, 11'd0);
`else
        frame(1'b0, 1'b0, 1'b0, 11'd0);
`endif
        topLeftX = 11'd100;
        empty_frames(4);

        // Reset during cooldown aborts everything.
        hit(11'd130);
        frame(1'b1, 1'b1, 1'b0, 11'd0);
        empty_frames(1);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        chk("midrst_dirToggle", int'(dirToggle), 0);
        chk("midrst_collision", int'(collision), 0);
        chk("midrst_hitCount", int'(hitCount), 0);
        exp_hc = 8'd0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        repeat (3) @(negedge clk);
        hit(11'd130);
        frame(1'b1, 1'b1, 1'b0, 11'd0);
        empty_frames(4);

        // topLeftX near zero: -10, hit at X=20 lies right of centre (6).
        topLeftX = -11'sd10;
        hit(11'd20);
        frame(1'b1, 1'b1, 1'b0, 11'd0);
        topLeftX = 11'd100;
        empty_frames(4);

        repeat (4) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        chk("pulse_count", pulse_seen, exp_pulses);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
